// File: rtl/average_sample_feeder_if.sv
// Sample-feeder bus: upstream valid/ready sample input plus the averager-side strobes and status.
// The slave modport is the feeder's view; master is the environment driving it.
interface average_sample_feeder_if #(
  parameter int W = 8
);
  logic [W-1:0] in_data;
  logic         in_valid;
  logic         in_ready;
  logic         avg_done;
  logic         avg_load;
  logic         start;
  logic [W-1:0] sample;
  logic         busy;
  logic [7:0]   frame_cnt;
  logic         protocol_err;

  modport slave (
    input  in_data,
    input  in_valid,
    input  avg_done,
    input  avg_load,
    output in_ready,
    output start,
    output sample,
    output busy,
    output frame_cnt,
    output protocol_err
  );

  modport master (
    output in_data,
    output in_valid,
    output avg_done,
    output avg_load,
    input  in_ready,
    input  start,
    input  sample,
    input  busy,
    input  frame_cnt,
    input  protocol_err
  );
endinterface

// File: rtl/average_sample_feeder.sv
// Buffers N samples from a valid/ready source, then starts the averager and streams them
// one per avg_load strobe; counts frames and flags stray load strobes.
module average_sample_feeder #(
  parameter int N = 4,
  parameter int W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  average_sample_feeder_if.slave io_bus
);

  localparam int            PW   = (N > 1) ? $clog2(N) : 1;
  localparam logic [PW-1:0] LAST = PW'(N - 1);

  typedef enum logic [1:0] {
    S_FILL,
    S_WAIT,
    S_START,
    S_STREAM
  } state_t;

  state_t        r_state;
  state_t        w_next_state;
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] w_next_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] w_next_rd_ptr;
  logic [7:0]    r_frame_cnt;
  logic [7:0]    w_next_frame_cnt;
  logic          r_protocol_err;
  logic          w_next_protocol_err;
  logic [W-1:0]  r_buf [N];

  logic          w_accept;
  logic          w_in_ready;
  logic          w_start;
  logic          w_busy;
  logic [W-1:0]  w_sample;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= S_FILL;
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_frame_cnt    <= '0;
      r_protocol_err <= 1'b0;
    end else begin
      r_state        <= w_next_state;
      r_wr_ptr       <= w_next_wr_ptr;
      r_rd_ptr       <= w_next_rd_ptr;
      r_frame_cnt    <= w_next_frame_cnt;
      r_protocol_err <= w_next_protocol_err;
    end
  end

  // in_ready is gated by rst so the source sees no acceptance while reset is held.
  always_comb begin
    w_next_state        = r_state;
    w_next_wr_ptr       = r_wr_ptr;
    w_next_rd_ptr       = r_rd_ptr;
    w_next_frame_cnt    = r_frame_cnt;
    w_next_protocol_err = r_protocol_err |
                          (io_bus.avg_load & (r_state != S_STREAM));
    w_accept            = 1'b0;
    w_in_ready          = 1'b0;
    w_start             = 1'b0;
    w_busy              = 1'b1;
    w_sample            = '0;

    case (r_state)
      S_FILL: begin
        w_busy     = 1'b0;
        w_in_ready = ~rst;
        w_accept   = io_bus.in_valid & w_in_ready;
        if (w_accept) begin
          if (r_wr_ptr == LAST) begin
            w_next_wr_ptr = '0;
            w_next_state  = S_WAIT;
          end else begin
            w_next_wr_ptr = r_wr_ptr + PW'(1);
          end
        end
      end

      S_WAIT: begin
        if (io_bus.avg_done) begin
          w_next_state = S_START;
        end
      end

      S_START: begin
        w_start       = 1'b1;
        w_next_rd_ptr = '0;
        w_next_state  = S_STREAM;
      end

      S_STREAM: begin
        w_sample = r_buf[r_rd_ptr];
        if (io_bus.avg_load) begin
          if (r_rd_ptr == LAST) begin
            w_next_rd_ptr    = '0;
            w_next_frame_cnt = r_frame_cnt + 8'd1;
            w_next_state     = S_FILL;
          end else begin
            w_next_rd_ptr = r_rd_ptr + PW'(1);
          end
        end
      end

      default: begin
        w_next_state = S_FILL;
      end
    endcase
  end

  // Sample storage needs no reset; contents only matter once a full frame is written.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_buf[r_wr_ptr] <= io_bus.in_data;
    end
  end

  assign io_bus.in_ready     = w_in_ready;
  assign io_bus.start        = w_start;
  assign io_bus.busy         = w_busy;
  assign io_bus.sample       = w_sample;
  assign io_bus.frame_cnt    = r_frame_cnt;
  assign io_bus.protocol_err = r_protocol_err;

endmodule
